fetch_unit: RTL and testbench

//   Instruction fetch stage driven by the pipeline hazard controller. Holds the PC, issues

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with single-outstanding memory requests
module fetch_unit #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    INST_BYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  branch,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  fetch_done,
   output logic                  if_valid,
   output logic [ADDR_WIDTH-1:0] if_pc,
   output logic [DATA_WIDTH-1:0] if_inst
);

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] pc, pc_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [DATA_WIDTH-1:0] inst_buf, buf_nxt;
   logic                  discard, discard_nxt;
   logic                  drop;
   logic                  consume;

   // The request line and the done flag are pure functions of the state, so an
   // asynchronous reset drops them in the same instant it forces ISSUE.
   assign mem_req    = (state == BUSY);
   assign fetch_done = (state == FULL);

   // The decoder only takes the buffered word when the controller is fully quiet.
   assign consume = (state == FULL) && !stall && !flush && !branch;

   // Fetch FSM state register together with pc, request address and buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ISSUE;
         pc       <= RESET_PC;
         mem_addr <= '0;
         inst_buf <= '0;
         discard  <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         mem_addr <= addr_nxt;
         inst_buf <= buf_nxt;
         discard  <= discard_nxt;
      end
   end

   // Next-state logic: redirects always win over a consume, and an in-flight
   // request is never abandoned; a stale reply is simply dropped on arrival.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      addr_nxt    = mem_addr;
      buf_nxt     = inst_buf;
      discard_nxt = discard;
      drop        = 1'b0;

      if (branch) begin
         pc_nxt = branch_target;
      end

      case (state)
         ISSUE: begin
            addr_nxt  = branch ? branch_target : pc;
            state_nxt = BUSY;
         end
         BUSY: begin
            // A redirect back to the address already in flight keeps the reply.
            drop = discard || (branch && (branch_target != mem_addr));
            if (mem_ack) begin
               if (drop) begin
                  discard_nxt = 1'b0;
                  state_nxt   = ISSUE;
               end else begin
                  buf_nxt   = mem_rdata;
                  state_nxt = FULL;
               end
            end else begin
               discard_nxt = drop;
            end
         end
         FULL: begin
            if (branch) begin
               if (branch_target != pc) begin
                  state_nxt = ISSUE;
               end
            end else if (consume) begin
               pc_nxt    = pc + ADDR_WIDTH'(INST_BYTES);
               state_nxt = ISSUE;
            end
         end
         default: begin
            state_nxt = ISSUE;
         end
      endcase
   end

   // IF/ID register: load on consume, bubble unless stalled, flush beats stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_valid <= 1'b0;
         if_pc    <= '0;
         if_inst  <= '0;
      end else if (consume) begin
         if_valid <= 1'b1;
         if_pc    <= pc;
         if_inst  <= inst_buf;
      end else if (!stall || flush) begin
         if_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        branch;
   logic [31:0] branch_target;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        fetch_done;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;

   int n_tests = 0;
   int n_fail  = 0;

   // memory model: word content is a fixed function of its address
   logic force_ack;
   int   lat;
   int   wcnt;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   assign mem_ack   = force_ack | (mem_req & (wcnt >= lat));
   assign mem_rdata = word_of(mem_addr);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) wcnt <= 0;
      else if (!mem_req || mem_ack) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   fetch_unit #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .RESET_PC   (32'h0),
      .INST_BYTES (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .flush         (flush),
      .branch        (branch),
      .branch_target (branch_target),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .fetch_done    (fetch_done),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_inst       (if_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out, expected event did not occur", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall = 0; flush = 0; branch = 0; branch_target = 0;
      force_ack = 0; lat = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      clear_inputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   task automatic wait_valid(input int bound, output bit ok);
      ok = 0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (if_valid) begin
            ok = 1;
            break;
         end
      end
   endtask

   typedef struct {
      logic        stall;
      logic        flush;
      logic        branch;
      logic [31:0] target;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_fd;
      logic        e_v;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
   } vec_t;

   function automatic vec_t mk(input logic s, input logic req, input logic [31:0] addr,
                               input logic fd, input logic v, input logic [31:0] pc,
                               input logic [31:0] inst);
      vec_t r;
      r.stall = s; r.flush = 0; r.branch = 0; r.target = 0;
      r.e_req = req; r.e_addr = addr; r.e_fd = fd; r.e_v = v; r.e_pc = pc; r.e_inst = inst;
      return r;
   endfunction

   vec_t vt[14];

   // random-phase model state
   logic [31:0] model_pc;
   logic        pr_req, pr_ack, pr_stall, pr_flush, pr_branch, pr_v;
   logic [31:0] pr_addr, pr_target, pr_pc, pr_inst;
   int          deliveries;

   initial begin
      bit ok;
      logic [31:0] w0, w4, w8;
      w0 = word_of(32'h0);
      w4 = word_of(32'h4);
      w8 = word_of(32'h8);

      // reset state
      rst_n = 0;
      clear_inputs();
      @(posedge clk);
      #1;
      chk("reset mem_req", {31'd0, mem_req}, 0);
      chk("reset mem_addr", mem_addr, 0);
      chk("reset fetch_done", {31'd0, fetch_done}, 0);
      chk("reset if_valid", {31'd0, if_valid}, 0);
      chk("reset if_pc", if_pc, 0);
      chk("reset if_inst", if_inst, 0);
      rst_n = 1;

      // sequential fetch with zero-wait memory, then a 5-cycle stall while FULL at pc=8
      vt[0]  = mk(0, 1, 32'h0, 0, 0, 32'h0, 32'h0);
      vt[1]  = mk(0, 0, 32'h0, 1, 0, 32'h0, 32'h0);
      vt[2]  = mk(0, 0, 32'h0, 0, 1, 32'h0, w0);
      vt[3]  = mk(0, 1, 32'h4, 0, 0, 32'h0, w0);
      vt[4]  = mk(0, 0, 32'h4, 1, 0, 32'h0, w0);
      vt[5]  = mk(0, 0, 32'h4, 0, 1, 32'h4, w4);
      vt[6]  = mk(0, 1, 32'h8, 0, 0, 32'h4, w4);
      vt[7]  = mk(0, 0, 32'h8, 1, 0, 32'h4, w4);
      for (int i = 8; i < 13; i++) vt[i] = mk(1, 0, 32'h8, 1, 0, 32'h4, w4);
      vt[13] = mk(0, 0, 32'h8, 0, 1, 32'h8, w8);

      for (int i = 0; i < 14; i++) begin
         stall = vt[i].stall; flush = vt[i].flush;
         branch = vt[i].branch; branch_target = vt[i].target;
         tick();
         chk($sformatf("vec%0d mem_req", i), {31'd0, mem_req}, {31'd0, vt[i].e_req});
         chk($sformatf("vec%0d mem_addr", i), mem_addr, vt[i].e_addr);
         chk($sformatf("vec%0d fetch_done", i), {31'd0, fetch_done}, {31'd0, vt[i].e_fd});
         chk($sformatf("vec%0d if_valid", i), {31'd0, if_valid}, {31'd0, vt[i].e_v});
         chk($sformatf("vec%0d if_pc", i), if_pc, vt[i].e_pc);
         chk($sformatf("vec%0d if_inst", i), if_inst, vt[i].e_inst);
      end

      // redirect while BUSY with a slow reply: stale data dropped, refetch at target
      do_reset();
      branch = 1; branch_target = 32'h10; lat = 4;
      tick();
      branch_target = 32'h40;
      tick();
      branch = 0; branch_target = 0;
      chk("busy redirect mem_req held", {31'd0, mem_req}, 1);
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         if (mem_req) chk("busy redirect addr held", mem_addr, 32'h10);
         if (mem_ack) begin
            ok = 1;
            tick();
            break;
         end
         tick();
      end
      if (!ok) timeout_fail("busy redirect ack");
      lat = 0;
      chk("busy redirect dropped", {31'd0, fetch_done}, 0);
      tick();
      chk("busy redirect new req", {31'd0, mem_req}, 1);
      chk("busy redirect new addr", mem_addr, 32'h40);
      wait_valid(10, ok);
      if (!ok) timeout_fail("busy redirect deliver");
      else begin
         chk("busy redirect if_pc", if_pc, 32'h40);
         chk("busy redirect if_inst", if_inst, word_of(32'h40));
      end

      // repeated redirect to the current pc while FULL and stalled keeps the buffer
      do_reset();
      stall = 1; branch = 1; branch_target = 32'h20;
      tick();
      branch = 0;
      tick();
      chk("same target full", {31'd0, fetch_done}, 1);
      branch = 1; branch_target = 32'h20;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("same target kept %0d", i), {31'd0, fetch_done}, 1);
         chk($sformatf("same target no req %0d", i), {31'd0, mem_req}, 0);
         chk($sformatf("same target bubble %0d", i), {31'd0, if_valid}, 0);
      end
      branch = 0; stall = 0;
      tick();
      chk("same target if_valid", {31'd0, if_valid}, 1);
      chk("same target if_pc", if_pc, 32'h20);
      chk("same target if_inst", if_inst, word_of(32'h20));

      // ack and redirect in the same cycle
      do_reset();
      tick();
      branch = 1; branch_target = 32'h80;
      tick();
      branch = 0; branch_target = 0;
      chk("ack+branch no full", {31'd0, fetch_done}, 0);
      chk("ack+branch issue", {31'd0, mem_req}, 0);
      tick();
      chk("ack+branch req", {31'd0, mem_req}, 1);
      chk("ack+branch addr", mem_addr, 32'h80);
      wait_valid(10, ok);
      if (!ok) timeout_fail("ack+branch deliver");
      else chk("ack+branch if_pc", if_pc, 32'h80);

      // asynchronous reset in the middle of a request
      do_reset();
      wait_valid(10, ok);
      if (!ok) timeout_fail("reset-mid prep");
      stall = 1; lat = 10;
      tick();
      tick();
      chk("reset-mid busy", {31'd0, mem_req}, 1);
      chk("reset-mid held valid", {31'd0, if_valid}, 1);
      #2;
      rst_n = 0;
      #1;
      chk("reset-mid mem_req", {31'd0, mem_req}, 0);
      chk("reset-mid if_valid", {31'd0, if_valid}, 0);
      chk("reset-mid fetch_done", {31'd0, fetch_done}, 0);
      force_ack = 1; stall = 0; lat = 0;
      tick();
      tick();
      chk("stray ack ignored", {31'd0, fetch_done}, 0);
      rst_n = 1;
      tick();
      chk("after reset req", {31'd0, mem_req}, 1);
      chk("after reset addr", mem_addr, 32'h0);
      force_ack = 0;
      tick();
      chk("after reset full", {31'd0, fetch_done}, 1);
      tick();
      chk("after reset if_valid", {31'd0, if_valid}, 1);
      chk("after reset if_pc", if_pc, 32'h0);
      chk("after reset if_inst", if_inst, word_of(32'h0));

      // randomized controller and memory timing against the architectural pc model
      do_reset();
      model_pc = 32'h0;
      deliveries = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int pick;
         if (!mem_req) lat = $urandom_range(0, 3);
         stall  = ($urandom_range(0, 99) < 25);
         flush  = ($urandom_range(0, 99) < 10);
         branch = ($urandom_range(0, 99) < 8);
         pick = $urandom_range(0, 5);
         case (pick)
            0: branch_target = 32'h0;
            1: branch_target = 32'h40;
            2: branch_target = 32'h80;
            3: branch_target = model_pc;
            4: branch_target = 32'hFFFF_FFFC;
            default: branch_target = mem_addr;
         endcase
         #1;
         pr_req = mem_req; pr_ack = mem_ack; pr_addr = mem_addr;
         pr_stall = stall; pr_flush = flush; pr_branch = branch; pr_target = branch_target;
         pr_v = if_valid; pr_pc = if_pc; pr_inst = if_inst;
         @(posedge clk);
         #1;
         if (pr_req && !pr_ack) begin
            chk("rand req held", {31'd0, mem_req}, 1);
            chk("rand addr stable", mem_addr, pr_addr);
         end
         if (pr_stall && !pr_flush) begin
            chk("rand stall valid", {31'd0, if_valid}, {31'd0, pr_v});
            chk("rand stall pc", if_pc, pr_pc);
            chk("rand stall inst", if_inst, pr_inst);
         end else if (pr_stall || pr_flush || pr_branch) begin
            chk("rand bubble", {31'd0, if_valid}, 0);
         end else if (if_valid) begin
            deliveries++;
            chk("rand if_pc", if_pc, model_pc);
            chk("rand if_inst", if_inst, word_of(model_pc));
         end
         if (pr_branch) model_pc = pr_target;
         else if (!pr_stall && if_valid) model_pc = model_pc + 32'd4;
      end
      chk("rand throughput", {31'd0, (deliveries >= 100)}, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
